// File: rtl/br_pkg.sv
// Shared constants and immediate decoders for the branch/jump resolution unit.
// The immediate extractors return 32-bit sign-extended values.
package br_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/br_resolve_unit_if.sv
// Operand/result bus of the branch resolution unit, including its counter controls.
// slave is the unit's view; master is the upstream/downstream side driving it.
interface br_resolve_unit_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic [N-1:0]     pc;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic             pred_taken;
  logic [N-1:0]     pred_target;
  logic             out_valid;
  logic             out_ready;
  logic             br_taken;
  logic [N-1:0]     br_target;
  logic [N-1:0]     link;
  logic             mispredict;
  logic             flush;
  logic             illegal;
  logic             misalign;
  logic             cnt_clr;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  modport slave (
    input  in_valid, inst, pc, A, B, pred_taken, pred_target, out_ready, cnt_clr,
    output in_ready, out_valid, br_taken, br_target, link, mispredict, flush,
           illegal, misalign, br_cnt, mp_cnt
  );

  modport master (
    output in_valid, inst, pc, A, B, pred_taken, pred_target, out_ready, cnt_clr,
    input  in_ready, out_valid, br_taken, br_target, link, mispredict, flush,
           illegal, misalign, br_cnt, mp_cnt
  );
endinterface

// File: rtl/br_cond.sv
// Combinational branch condition evaluator: funct3 selects the comparison of A and B.
// funct3 010/011 are not branch encodings and report illegal with cond forced low.
module br_cond
  import br_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   funct3_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         cond_o,
  output logic         illegal_o
);

  logic signed [N-1:0] a_s;
  logic signed [N-1:0] b_s;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = (a_i == b_i);
      F3_BNE:  cond_o = (a_i != b_i);
      F3_BLT:  cond_o = (a_s <  b_s);
      F3_BGE:  cond_o = (a_s >= b_s);
      F3_BLTU: cond_o = (a_i <  b_i);
      F3_BGEU: cond_o = (a_i >= b_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch/jump resolution stage: resolves outcome, target and link, checks the fetch
// prediction, registers the result behind valid/ready and keeps saturating counters.
module br_resolve_unit
  import br_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  br_resolve_unit_if.slave  bus
);

  logic [6:0]          opcode;
  logic                is_br, is_jal, is_jalr, is_ctl;
  logic                cond, cond_ill;
  logic signed [N-1:0] imm_i_s, imm_b_s, imm_j_s;
  logic [N-1:0]        pc4, jalr_sum, tgt_raw;
  logic                accept;

  logic                taken_d, mp_d, ill_d, mis_d;
  logic [N-1:0]        target_d;
  logic                vld_q, taken_q, mp_q, ill_q, mis_q;
  logic [N-1:0]        target_q, link_q;
  logic [CNT_W-1:0]    br_cnt_d, br_cnt_q, mp_cnt_d, mp_cnt_q;

  br_cond #(.N(N)) u_cond (
    .funct3_i  (bus.inst[14:12]),
    .a_i       (bus.A),
    .b_i       (bus.B),
    .cond_o    (cond),
    .illegal_o (cond_ill)
  );

  assign opcode  = bus.inst[6:0];
  assign is_br   = (opcode == OP_BRANCH);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign is_ctl  = (is_br & ~cond_ill) | is_jal | is_jalr;

  assign imm_i_s  = N'(imm_i(bus.inst));
  assign imm_b_s  = N'(imm_b(bus.inst));
  assign imm_j_s  = N'(imm_j(bus.inst));
  assign pc4      = bus.pc + N'(4);
  assign jalr_sum = bus.A + imm_i_s;

  always_comb begin
    tgt_raw = pc4;
    if (is_br)        tgt_raw = bus.pc + imm_b_s;
    else if (is_jal)  tgt_raw = bus.pc + imm_j_s;
    else if (is_jalr) tgt_raw = {jalr_sum[N-1:1], 1'b0};
  end

  // Non-control opcodes fall through as not-taken with every flag clear.
  always_comb begin
    ill_d    = is_br & cond_ill;
    taken_d  = is_br ? (cond & ~cond_ill) : (is_jal | is_jalr);
    target_d = taken_d ? tgt_raw : pc4;
    mis_d    = taken_d & target_d[1];
    mp_d     = is_ctl & ((taken_d != bus.pred_taken) |
                         (taken_d & bus.pred_taken & (bus.pred_target != target_d)));
  end

  assign bus.in_ready = ~vld_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // Result register: loads on accept, holds under back-pressure, drains on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 1'b0;
      taken_q  <= 1'b0;
      mp_q     <= 1'b0;
      ill_q    <= 1'b0;
      mis_q    <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
    end else if (accept) begin
      vld_q    <= 1'b1;
      taken_q  <= taken_d;
      mp_q     <= mp_d;
      ill_q    <= ill_d;
      mis_q    <= mis_d;
      target_q <= target_d;
      link_q   <= pc4;
    end else if (bus.out_ready) begin
      vld_q    <= 1'b0;
    end
  end

  // Clear has priority over an increment in the same cycle.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (bus.cnt_clr) begin
      br_cnt_d = '0;
      mp_cnt_d = '0;
    end else if (accept) begin
      if (is_ctl && br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mp_d   && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.br_taken   = taken_q;
  assign bus.br_target  = target_q;
  assign bus.link       = link_q;
  assign bus.mispredict = mp_q;
  assign bus.illegal    = ill_q;
  assign bus.misalign   = mis_q;
  assign bus.flush      = vld_q & bus.out_ready & mp_q;
  assign bus.br_cnt     = br_cnt_q;
  assign bus.mp_cnt     = mp_cnt_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit: a table of hand-computed vectors plus
// back-pressure, counter saturation/clear and reset-while-held sequences.
module tb_br_resolve_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  br_resolve_unit_if #(.N(32), .CNT_W(16)) bus ();
  br_resolve_unit #(.N(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] inst, pc, a, b;
    logic        pt;
    logic [31:0] ptgt;
    logic        tk;
    logic [31:0] tgt;
    logic        mp, ill, mis, cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  int   tests = 0;
  int   fails = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int imm);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm);
    logic [20:0] i;
    i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input int imm);
    logic [11:0] i;
    i = imm[11:0];
    return {i, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.inst        = v.inst;
    bus.pc          = v.pc;
    bus.A           = v.a;
    bus.B           = v.b;
    bus.pred_taken  = v.pt;
    bus.pred_target = v.ptgt;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    @(negedge clk);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (v.cnt) exp_br++;
    if (v.mp)  exp_mp++;
    chk($sformatf("v%0d out_valid", k), 32'(bus.out_valid), 32'd1);
    chk($sformatf("v%0d taken", k), 32'(bus.br_taken), 32'(v.tk));
    chk($sformatf("v%0d target", k), bus.br_target, v.tgt);
    chk($sformatf("v%0d link", k), bus.link, v.pc + 32'd4);
    chk($sformatf("v%0d mispredict", k), 32'(bus.mispredict), 32'(v.mp));
    chk($sformatf("v%0d flush", k), 32'(bus.flush), 32'(v.mp));
    chk($sformatf("v%0d illegal", k), 32'(bus.illegal), 32'(v.ill));
    chk($sformatf("v%0d misalign", k), 32'(bus.misalign), 32'(v.mis));
    chk($sformatf("v%0d br_cnt", k), 32'(bus.br_cnt), 32'(exp_br));
    chk($sformatf("v%0d mp_cnt", k), 32'(bus.mp_cnt), 32'(exp_mp));
  endtask

  initial begin
    //            inst                      pc         A            B            pt  ptgt       tk  tgt        mp ill mis cnt
    vecs[0]  = '{enc_b(3'b100, 16),       32'h100,  32'hFFFFFFFF, 32'h1,       1'b0, 32'h0,    1'b1, 32'h110,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{enc_b(3'b110, 16),       32'h200,  32'hFFFFFFFF, 32'h1,       1'b0, 32'h0,    1'b0, 32'h204,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{enc_jalr(0),             32'h300,  32'h2003,     32'h0,       1'b1, 32'h2002, 1'b1, 32'h2002, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{enc_b(3'b000, -8),       32'h400,  32'h5,        32'h5,       1'b1, 32'h3F8,  1'b1, 32'h3F8,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{enc_b(3'b001, 8),        32'h400,  32'h5,        32'h5,       1'b1, 32'h408,  1'b0, 32'h404,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{enc_b(3'b101, 32),       32'h500,  32'hFFFFFFFD, 32'hFFFFFFFD,1'b1, 32'h524,  1'b1, 32'h520,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{enc_b(3'b111, 32),       32'h600,  32'h1,        32'h80000000,1'b0, 32'h0,    1'b0, 32'h604,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{enc_b(3'b100, 32),       32'h700,  32'h1,        32'hFFFFFFFF,1'b0, 32'h0,    1'b0, 32'h704,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{enc_b(3'b010, 16),       32'h800,  32'h0,        32'h0,       1'b1, 32'h810,  1'b0, 32'h804,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{enc_b(3'b011, 16),       32'h880,  32'h3,        32'h3,       1'b0, 32'h0,    1'b0, 32'h884,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{enc_j(6),                32'h900,  32'h0,        32'h0,       1'b0, 32'h0,    1'b1, 32'h906,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{32'h00100093,            32'hA00,  32'h0,        32'h0,       1'b1, 32'hA40,  1'b0, 32'hA04,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{enc_j(-256),             32'h1000, 32'h0,        32'h0,       1'b1, 32'hF00,  1'b1, 32'hF00,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{enc_b(3'b111, -4096),    32'h1100, 32'hFFFFFFFF, 32'h1,       1'b0, 32'h0,    1'b1, 32'h100,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{enc_jalr(-1),            32'h1200, 32'h1000,     32'h0,       1'b1, 32'hFFE,  1'b1, 32'hFFE,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{enc_b(3'b110, 64),       32'h1300, 32'h1,        32'hFFFFFFFF,1'b1, 32'h1340, 1'b1, 32'h1340, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.cnt_clr = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst target", bus.br_target, 32'd0);
    chk("rst br_cnt", 32'(bus.br_cnt), 32'd0);
    chk("rst mp_cnt", 32'(bus.mp_cnt), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) run_vec(k);

    // Back-pressure: one op taken, further ops refused while result is held.
    @(negedge clk);
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    drive(vecs[4]);
    exp_br++;
    exp_mp++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d target", c), bus.br_target, 32'h110);
      chk($sformatf("bp%0d taken", c), 32'(bus.br_taken), 32'd1);
      chk($sformatf("bp%0d flush", c), 32'(bus.flush), 32'd0);
      chk($sformatf("bp%0d br_cnt", c), 32'(bus.br_cnt), 32'(exp_br));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("bp release flush", 32'(bus.flush), 32'd1);
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp drained out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp drained flush", 32'(bus.flush), 32'd0);
    chk("bp mp_cnt", 32'(bus.mp_cnt), 32'(exp_mp));

    // Counter clear, then stream one mispredicting branch per cycle to saturation.
    @(negedge clk);
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr br_cnt", 32'(bus.br_cnt), 32'd0);
    chk("clr mp_cnt", 32'(bus.mp_cnt), 32'd0);
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat br_cnt FFFE", 32'(bus.br_cnt), 32'hFFFE);
    chk("sat mp_cnt FFFE", 32'(bus.mp_cnt), 32'hFFFE);
    @(posedge clk);
    #1;
    chk("sat br_cnt FFFF", 32'(bus.br_cnt), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("sat br_cnt hold", 32'(bus.br_cnt), 32'hFFFF);
    chk("sat mp_cnt hold", 32'(bus.mp_cnt), 32'hFFFF);
    @(negedge clk);
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr+accept br_cnt", 32'(bus.br_cnt), 32'd0);
    chk("clr+accept mp_cnt", 32'(bus.mp_cnt), 32'd0);
    chk("clr+accept out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    bus.in_valid = 1'b0;

    // Reset while a result is held drops it.
    @(negedge clk);
    drive(vecs[10]);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("held out_valid", 32'(bus.out_valid), 32'd1);
    chk("held target", bus.br_target, 32'h906);
    chk("held br_cnt", 32'(bus.br_cnt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst held out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst held taken", 32'(bus.br_taken), 32'd0);
    chk("rst held target", bus.br_target, 32'd0);
    chk("rst held link", bus.link, 32'd0);
    chk("rst held br_cnt", 32'(bus.br_cnt), 32'd0);
    chk("rst held in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
